// File: rtl/pipe_modaddsub_if.sv
// Operand/result handshake bundle for pipe_modaddsub.
// master drives operands and out_ready; slave is the adder/subtractor.
interface pipe_modaddsub_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [N-1:0]     input1;
  logic [N-1:0]     input2;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     answer;
  logic [TAG_W-1:0] tag_out;
  logic             carry_out;
  logic             range_err;

  modport master (
    output in_valid, mode, input1, input2, tag_in, out_ready,
    input  in_ready, out_valid, answer, tag_out, carry_out, range_err
  );

  modport slave (
    input  in_valid, mode, input1, input2, tag_in, out_ready,
    output in_ready, out_valid, answer, tag_out, carry_out, range_err
  );
endinterface

// File: rtl/pipe_modaddsub.sv
// Pipelined N-bit add/sub with SEG-bit registered carry segments and an
// optional mod-Q correction stage; all stages advance together on adv.
module pipe_modaddsub #(
  parameter int unsigned N       = 32,
  parameter int unsigned SEG     = 8,
  parameter int unsigned Q       = 3329,
  parameter int unsigned USE_MOD = 1,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipe_modaddsub_if.slave  bus
);

  localparam int unsigned NSEG = N / SEG;
  localparam logic [N-1:0] QN  = N'(Q);

  if (N % SEG != 0) begin : g_chk_seg
    $error("pipe_modaddsub: N (%0d) must be a multiple of SEG (%0d)", N, SEG);
  end
  if (Q == 0 || (N < 32 && (Q >> N) != 0)) begin : g_chk_q
    $error("pipe_modaddsub: Q (%0d) must satisfy 0 < Q < 2^N", Q);
  end

  logic         adv;
  logic         out_vld;
  logic [N-1:0] b_in;
  logic         rerr_in;

  assign adv          = ~out_vld | bus.out_ready;
  assign bus.in_ready = adv;
  assign b_in         = bus.mode ? ~bus.input2 : bus.input2;
  assign rerr_in      = (USE_MOD != 0) && ((bus.input1 >= QN) || (bus.input2 >= QN));

  // Each stage consumes the low SEG bits of the remaining operands, appends its
  // sum segment to the finished low result, and passes the rest upward.
  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    localparam int unsigned LO = s * SEG;
    localparam int unsigned HI = LO + SEG;

    logic [N-LO-1:0]  a_p, b_p;
    logic             vld_p, cy_p, mode_p, rerr_p;
    logic [TAG_W-1:0] tag_p;
    logic [HI-1:0]    res_new;
    logic [SEG:0]     sum;

    logic             vld_q, vld_d, cy_q, cy_d, mode_q, mode_d, rerr_q, rerr_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [HI-1:0]    res_q, res_d;

    if (s == 0) begin : g_head
      assign a_p     = bus.input1;
      assign b_p     = b_in;
      assign vld_p   = bus.in_valid;
      assign cy_p    = bus.mode;
      assign mode_p  = bus.mode;
      assign rerr_p  = rerr_in;
      assign tag_p   = bus.tag_in;
      assign res_new = sum[SEG-1:0];
    end else begin : g_body
      assign a_p     = g_seg[s-1].g_op.a_q;
      assign b_p     = g_seg[s-1].g_op.b_q;
      assign vld_p   = g_seg[s-1].vld_q;
      assign cy_p    = g_seg[s-1].cy_q;
      assign mode_p  = g_seg[s-1].mode_q;
      assign rerr_p  = g_seg[s-1].rerr_q;
      assign tag_p   = g_seg[s-1].tag_q;
      assign res_new = {sum[SEG-1:0], g_seg[s-1].res_q};
    end

    assign sum = {1'b0, a_p[SEG-1:0]} + {1'b0, b_p[SEG-1:0]} + {{SEG{1'b0}}, cy_p};

    always_comb begin
      vld_d  = vld_q;
      cy_d   = cy_q;
      mode_d = mode_q;
      rerr_d = rerr_q;
      tag_d  = tag_q;
      res_d  = res_q;
      if (adv) begin
        vld_d  = vld_p;
        cy_d   = sum[SEG];
        mode_d = mode_p;
        rerr_d = rerr_p;
        tag_d  = tag_p;
        res_d  = res_new;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        cy_q   <= 1'b0;
        mode_q <= 1'b0;
        rerr_q <= 1'b0;
        tag_q  <= '0;
        res_q  <= '0;
      end else begin
        vld_q  <= vld_d;
        cy_q   <= cy_d;
        mode_q <= mode_d;
        rerr_q <= rerr_d;
        tag_q  <= tag_d;
        res_q  <= res_d;
      end
    end

    if (s < NSEG - 1) begin : g_op
      logic [N-HI-1:0] a_q, a_d, b_q, b_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_p[N-LO-1:SEG];
          b_d = b_p[N-LO-1:SEG];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  logic [N-1:0]     r_raw;
  logic             c_raw, vld_raw, mode_raw, rerr_raw;
  logic [TAG_W-1:0] tag_raw;

  assign r_raw    = g_seg[NSEG-1].res_q;
  assign c_raw    = g_seg[NSEG-1].cy_q;
  assign vld_raw  = g_seg[NSEG-1].vld_q;
  assign mode_raw = g_seg[NSEG-1].mode_q;
  assign rerr_raw = g_seg[NSEG-1].rerr_q;
  assign tag_raw  = g_seg[NSEG-1].tag_q;

  if (USE_MOD != 0) begin : g_mod
    logic             vld_q, vld_d, cout_q, cout_d, rerr_q, rerr_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [N-1:0]     ans_q, ans_d;

    // S-Q truncated to N bits equals R-Q mod 2^N, so bit N of S only feeds the compare.
    always_comb begin
      vld_d  = vld_q;
      cout_d = cout_q;
      rerr_d = rerr_q;
      tag_d  = tag_q;
      ans_d  = ans_q;
      if (adv) begin
        vld_d  = vld_raw;
        cout_d = mode_raw ^ c_raw;
        rerr_d = rerr_raw;
        tag_d  = tag_raw;
        if (mode_raw) begin
          ans_d = c_raw ? r_raw : r_raw + QN;
        end else begin
          ans_d = ({c_raw, r_raw} >= {1'b0, QN}) ? r_raw - QN : r_raw;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        cout_q <= 1'b0;
        rerr_q <= 1'b0;
        tag_q  <= '0;
        ans_q  <= '0;
      end else begin
        vld_q  <= vld_d;
        cout_q <= cout_d;
        rerr_q <= rerr_d;
        tag_q  <= tag_d;
        ans_q  <= ans_d;
      end
    end

    assign out_vld       = vld_q;
    assign bus.out_valid = vld_q;
    assign bus.answer    = ans_q;
    assign bus.carry_out = cout_q;
    assign bus.range_err = rerr_q;
    assign bus.tag_out   = tag_q;
  end else begin : g_wrap
    assign out_vld       = vld_raw;
    assign bus.out_valid = vld_raw;
    assign bus.answer    = r_raw;
    assign bus.carry_out = mode_raw ^ c_raw;
    assign bus.range_err = rerr_raw;
    assign bus.tag_out   = tag_raw;
  end

endmodule

// File: tb/tb_pipe_modaddsub.sv
// Scoreboard bench: mod-Q DUT (N=16,SEG=4,L=5) and wrap DUT (USE_MOD=0,L=4)
// side by side; drivers push expectations, per-DUT monitors pop and compare.
module tb_pipe_modaddsub;
  localparam int unsigned N     = 16;
  localparam int unsigned SEG   = 4;
  localparam int unsigned Q     = 3329;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned LM    = 5;
  localparam int unsigned LW    = 4;
  localparam int          QI    = 3329;

  typedef struct {
    logic [N-1:0]     ans;
    logic [TAG_W-1:0] tag;
    logic             cout;
    logic             rerr;
    int               lat_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          nvec = 0;
  int          nfail = 0;
  exp_t        q_m[$];
  exp_t        q_w[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_modaddsub_if #(.N(N), .TAG_W(TAG_W)) if_m ();
  pipe_modaddsub_if #(.N(N), .TAG_W(TAG_W)) if_w ();

  pipe_modaddsub #(.N(N), .SEG(SEG), .Q(Q), .USE_MOD(1), .TAG_W(TAG_W)) u_mod (
    .clk(clk), .rst(rst), .bus(if_m)
  );
  pipe_modaddsub #(.N(N), .SEG(SEG), .Q(Q), .USE_MOD(0), .TAG_W(TAG_W)) u_wrap (
    .clk(clk), .rst(rst), .bus(if_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [N-1:0] a, input logic [TAG_W-1:0] t,
                              input logic c, input logic r);
    exp_t e;
    e.ans = a; e.tag = t; e.cout = c; e.rerr = r; e.lat_cyc = -1;
    return e;
  endfunction

  function automatic exp_t model_mod(input logic md, input logic [N-1:0] a, input logic [N-1:0] b,
                                     input logic [TAG_W-1:0] t);
    exp_t e;
    int   ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    e.tag = t;
    e.rerr = (ia >= QI) || (ib >= QI);
    e.lat_cyc = -1;
    if (!md) begin
      r = ia + ib;
      e.cout = (r >= 65536);
      if (r >= QI) r = r - QI;
    end else begin
      r = ia - ib;
      e.cout = (r < 0);
      if (r < 0) r = r + QI;
    end
    e.ans = N'(r);
    return e;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that takes the beat.
  task automatic send(input bit to_mod, input logic md, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [TAG_W-1:0] t, input exp_t e_in,
                      input bit lat, input bit push);
    exp_t        e;
    int unsigned waited;
    bit          rdy;
    e = e_in;
    waited = 0;
    rdy = 1'b0;
    if (to_mod) begin
      if_m.mode = md; if_m.input1 = a; if_m.input2 = b; if_m.tag_in = t; if_m.in_valid = 1'b1;
    end else begin
      if_w.mode = md; if_w.input1 = a; if_w.input2 = b; if_w.tag_in = t; if_w.in_valid = 1'b1;
    end
    while (!rdy && waited < 50) begin
      @(negedge clk);
      rdy = to_mod ? if_m.in_ready : if_w.in_ready;
      if (!rdy) waited++;
    end
    if (!rdy) begin
      nvec++; nfail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
    end else begin
      e.lat_cyc = lat ? int'(cyc) + int'(to_mod ? LM : LW) : -1;
      if (push) begin
        if (to_mod) q_m.push_back(e);
        else q_w.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (to_mod) if_m.in_valid = 1'b0;
    else if_w.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((q_m.size() != 0 || q_w.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q_m.size() != 0 || q_w.size() != 0) begin
      nvec++; nfail++;
      $display("FAIL drain: %0d results outstanding, expected 0",
               q_m.size() + q_w.size());
      q_m.delete();
      q_w.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : mon_m
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && if_m.out_valid) begin
        if (q_m.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL mod_unexpected: result tag %0d answer %0d presented, expected none",
                   if_m.tag_out, if_m.answer);
        end else begin
          e = q_m[0];
          check("mod_answer", 32'(if_m.answer), 32'(e.ans));
          check("mod_tag", 32'(if_m.tag_out), 32'(e.tag));
          check("mod_carry", 32'(if_m.carry_out), 32'(e.cout));
          check("mod_range_err", 32'(if_m.range_err), 32'(e.rerr));
          if (if_m.out_ready) begin
            if (e.lat_cyc >= 0) check("mod_latency", cyc, 32'(e.lat_cyc));
            void'(q_m.pop_front());
          end
        end
      end
    end
  end

  initial begin : mon_w
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && if_w.out_valid) begin
        if (q_w.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL wrap_unexpected: result tag %0d answer %0d presented, expected none",
                   if_w.tag_out, if_w.answer);
        end else begin
          e = q_w[0];
          check("wrap_answer", 32'(if_w.answer), 32'(e.ans));
          check("wrap_tag", 32'(if_w.tag_out), 32'(e.tag));
          check("wrap_carry", 32'(if_w.carry_out), 32'(e.cout));
          check("wrap_range_err", 32'(if_w.range_err), 32'(e.rerr));
          if (if_w.out_ready) begin
            if (e.lat_cyc >= 0) check("wrap_latency", cyc, 32'(e.lat_cyc));
            void'(q_w.pop_front());
          end
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    if_m.in_valid = 1'b0; if_m.mode = 1'b0; if_m.input1 = '0; if_m.input2 = '0;
    if_m.tag_in = '0; if_m.out_ready = 1'b1;
    if_w.in_valid = 1'b0; if_w.mode = 1'b0; if_w.input1 = '0; if_w.input2 = '0;
    if_w.tag_in = '0; if_w.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(if_m.out_valid), 0);
    check("rst_answer", 32'(if_m.answer), 0);
    check("rst_tag_out", 32'(if_m.tag_out), 0);
    check("rst_carry_out", 32'(if_m.carry_out), 0);
    check("rst_range_err", 32'(if_m.range_err), 0);
    check("rst_in_ready", 32'(if_m.in_ready), 1);
    check("rst_wrap_out_valid", 32'(if_w.out_valid), 0);
    check("rst_wrap_answer", 32'(if_w.answer), 0);
    @(posedge clk);
    #1;

    // mod-Q directed vectors, back to back, latency checked
    send(1, 1'b0, 16'd3000,  16'd500,   4'd3, mk(16'd171,   4'd3, 1'b0, 1'b0), 1, 1);
    send(1, 1'b1, 16'd100,   16'd200,   4'd4, mk(16'd3229,  4'd4, 1'b1, 1'b0), 1, 1);
    send(1, 1'b1, 16'd200,   16'd100,   4'd5, mk(16'd100,   4'd5, 1'b0, 1'b0), 1, 1);
    send(1, 1'b0, 16'd3328,  16'd1,     4'd6, mk(16'd0,     4'd6, 1'b0, 1'b0), 1, 1);
    send(1, 1'b0, 16'd4000,  16'd10,    4'd7, mk(16'd681,   4'd7, 1'b0, 1'b1), 1, 1);
    send(1, 1'b0, 16'hFFFF,  16'hFFFF,  4'd8, mk(16'd62205, 4'd8, 1'b1, 1'b1), 1, 1);
    send(1, 1'b1, 16'd0,     16'd0,     4'd9, mk(16'd0,     4'd9, 1'b0, 1'b0), 1, 1);
    drain();

    // plain wrap directed vectors
    send(0, 1'b0, 16'hFFFF, 16'h0001, 4'd1, mk(16'h0000, 4'd1, 1'b1, 1'b0), 1, 1);
    send(0, 1'b1, 16'h0000, 16'h0001, 4'd2, mk(16'hFFFF, 4'd2, 1'b1, 1'b0), 1, 1);
    send(0, 1'b0, 16'h1234, 16'h4321, 4'd3, mk(16'h5555, 4'd3, 1'b0, 1'b0), 1, 1);
    send(0, 1'b1, 16'd5,    16'd3,    4'd4, mk(16'd2,    4'd4, 1'b0, 1'b0), 1, 1);
    drain();

    // 20 back-to-back beats with a 3-cycle downstream stall mid-stream
    fork
      begin
        logic          md;
        logic [N-1:0]  a, b;
        for (int unsigned i = 0; i < 20; i++) begin
          md = 1'($urandom_range(0, 1));
          a  = N'($urandom_range(0, Q - 1));
          b  = N'($urandom_range(0, Q - 1));
          send(1, md, a, b, TAG_W'(i), model_mod(md, a, b, TAG_W'(i)), 0, 1);
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1 if_m.out_ready = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(if_m.in_ready), 0);
          check("stall_out_valid", 32'(if_m.out_valid), 1);
        end
        @(posedge clk);
        #1 if_m.out_ready = 1'b1;
      end
    join
    drain();

    // reset with three beats in flight: none may emerge
    send(1, 1'b0, 16'd11, 16'd22, 4'd10, mk(16'd33, 4'd10, 1'b0, 1'b0), 0, 0);
    send(1, 1'b0, 16'd44, 16'd55, 4'd11, mk(16'd99, 4'd11, 1'b0, 1'b0), 0, 0);
    send(1, 1'b1, 16'd66, 16'd7,  4'd12, mk(16'd59, 4'd12, 1'b0, 1'b0), 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(if_m.out_valid), 0);
    check("midrst_in_ready", 32'(if_m.in_ready), 1);
    for (int unsigned k = 0; k < LM + 2; k++) begin
      @(negedge clk);
      check("midrst_no_emit", 32'(if_m.out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(1, 1'b1, 16'd1000, 16'd1, 4'd13, mk(16'd999, 4'd13, 1'b0, 1'b0), 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
